// File: rtl/dsp_coeff_loader_pkg.sv
// Shared definitions for the DSP coefficient loader: register map constants,
// status codes, loader state type and small arithmetic helpers.
package dsp_coeff_loader_pkg;

  localparam int unsigned FILTER_TAPS = 8;
  localparam logic [31:0] DSP_REGS_START_APB_ADDRESS = 32'h8C00_0100;

  localparam logic [1:0] LOAD_OK     = 2'd0;
  localparam logic [1:0] LOAD_SLVERR = 2'd1;
  localparam logic [1:0] LOAD_CKSUM  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_WSETUP  = 3'd2,
    ST_WACCESS = 3'd3,
    ST_RSETUP  = 3'd4,
    ST_RACCESS = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERROR   = 3'd7
  } loader_state_e;

  // Register address of coefficient idx; 32-bit wrap is intentional.
  function automatic logic [31:0] coeff_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + {idx[29:0], 2'b00};
  endfunction

  function automatic logic [31:0] sum32(input logic [31:0] a, input logic [31:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/dsp_coeff_loader_if.sv
// Coefficient stream plus APB initiator signals of the coefficient loader.
interface dsp_coeff_loader_if;

  logic [31:0] coeff_data_in;
  logic        coeff_valid_in;
  logic        coeff_ready_out;
  logic        psel_out;
  logic        penable_out;
  logic        pwrite_out;
  logic [31:0] paddr_out;
  logic [31:0] pwdata_out;
  logic [31:0] prdata_in;
  logic        pready_in;
  logic        pslverr_in;

  modport master (
    input  coeff_data_in, coeff_valid_in, prdata_in, pready_in, pslverr_in,
    output coeff_ready_out, psel_out, penable_out, pwrite_out, paddr_out, pwdata_out
  );

  modport slave (
    output coeff_data_in, coeff_valid_in, prdata_in, pready_in, pslverr_in,
    input  coeff_ready_out, psel_out, penable_out, pwrite_out, paddr_out, pwdata_out
  );

endinterface

// File: rtl/dsp_coeff_loader.sv
// Streams NUM_COEFFS words into consecutive APB registers, then optionally reads
// them back and compares the readback sum with the running write checksum.
module dsp_coeff_loader
  import dsp_coeff_loader_pkg::*;
#(
  parameter int unsigned NUM_COEFFS = 4 * FILTER_TAPS,
  parameter logic [31:0] BASE_ADDR  = DSP_REGS_START_APB_ADDRESS,
  parameter bit          VERIFY     = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_in,
  dsp_coeff_loader_if.master  bus,
  output logic                busy_out,
  output logic                done_out,
  output logic [1:0]          error_out,
  output logic [31:0]         checksum_out
);

  localparam int unsigned IDX_W = $clog2(NUM_COEFFS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COEFFS - 1);

  loader_state_e    state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      checksum_q, checksum_d;
  logic [31:0]      rsum_q, rsum_d;
  logic [1:0]       error_q, error_d;
  logic [31:0]      paddr_q, paddr_d;
  logic [31:0]      pwdata_q, pwdata_d;
  logic             psel_q, psel_d;
  logic             penable_q, penable_d;
  logic             pwrite_q, pwrite_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state, datapath updates and output decode of the next state.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    checksum_d = checksum_q;
    rsum_d     = rsum_q;
    error_d    = error_q;
    pwdata_d   = pwdata_q;

    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          checksum_d = 32'd0;
          rsum_d     = 32'd0;
          idx_d      = '0;
          error_d    = LOAD_OK;
          state_d    = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (bus.coeff_valid_in) begin
          pwdata_d   = bus.coeff_data_in;
          checksum_d = sum32(checksum_q, bus.coeff_data_in);
          state_d    = ST_WSETUP;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_WSETUP: state_d = ST_WACCESS;
      ST_WACCESS: begin
        if (!bus.pready_in) begin
          state_d = ST_WACCESS;
        end else if (bus.pslverr_in) begin
          error_d = LOAD_SLVERR;
          state_d = ST_ERROR;
        end else if (idx_q == LAST_IDX) begin
          idx_d = '0;
          if (VERIFY) begin
            state_d = ST_RSETUP;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_FETCH;
        end
      end
      ST_RSETUP: state_d = ST_RACCESS;
      // Readback: the final compare uses the sum including the current word.
      ST_RACCESS: begin
        if (!bus.pready_in) begin
          state_d = ST_RACCESS;
        end else if (bus.pslverr_in) begin
          error_d = LOAD_SLVERR;
          state_d = ST_ERROR;
        end else begin
          rsum_d = sum32(rsum_q, bus.prdata_in);
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (rsum_d == checksum_q) begin
              state_d = ST_DONE;
            end else begin
              error_d = LOAD_CKSUM;
              state_d = ST_ERROR;
            end
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_RSETUP;
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    ready_d   = (state_d == ST_FETCH);
    psel_d    = (state_d inside {ST_WSETUP, ST_WACCESS, ST_RSETUP, ST_RACCESS});
    penable_d = (state_d inside {ST_WACCESS, ST_RACCESS});
    pwrite_d  = (state_d inside {ST_WSETUP, ST_WACCESS});
    busy_d    = (state_d inside {ST_FETCH, ST_WSETUP, ST_WACCESS, ST_RSETUP, ST_RACCESS});
    done_d    = (state_d == ST_DONE);
    if (state_d inside {ST_WSETUP, ST_RSETUP}) begin
      paddr_d = coeff_addr(BASE_ADDR, 32'(idx_d));
    end else begin
      paddr_d = paddr_q;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      checksum_q <= 32'd0;
      rsum_q     <= 32'd0;
      error_q    <= LOAD_OK;
      paddr_q    <= 32'd0;
      pwdata_q   <= 32'd0;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      checksum_q <= checksum_d;
      rsum_q     <= rsum_d;
      error_q    <= error_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      pwrite_q   <= pwrite_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.coeff_ready_out = ready_q;
  assign bus.psel_out        = psel_q;
  assign bus.penable_out     = penable_q;
  assign bus.pwrite_out      = pwrite_q;
  assign bus.paddr_out       = paddr_q;
  assign bus.pwdata_out      = pwdata_q;
  assign busy_out            = busy_q;
  assign done_out            = done_q;
  assign error_out           = error_q;
  assign checksum_out        = checksum_q;

endmodule
